unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
Moore FSM that sequences the LED-matrix puzzle datapath. It drives the level counter, matrix reset, blink timer/counter and the column-source select. It walks the flow: idle -> level setup -> play -> 3-blink celebration -> next level, or final victory drawing. Sits beside fluxo_dados in the top level; all its outputs go directly to the datapath's control inputs.

Parameters:
ESPERA_VITORIA, 2000, clock cycles the victory drawing is held before returning to idle
W_ESPERA, 11, width of the internal victory-hold counter (must hold ESPERA_VITORIA-1)
TEMPO_LIMITE, 60000, cycles allowed per level (used only with TIMEOUT_EN)
W_LIMITE, 16, width of the timeout counter

Ports:
clock  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-low; low forces INICIAL immediately
iniciar  in  1  start/restart request, level-sensitive, sampled each cycle
nivel_concluido  in  1  current level solved (from matrix)
fimT  in  1  blink timer terminal count
fimP  in  1  blink counter at last blink
nivelIgualUltimoNivel  in  1  level counter at final level
contaN, zeraN, contaT, zeraT, contaP, zeraP, zeraM  out  1 each  datapath enables/clears, active-high
ganhou  out  1  selects victory drawing in reg_8x8
passou_nivel  out  1  columns taken from reg_8x8 instead of matrix
db_estado  out  4  current state code for debug display

Behaviour:
- Outputs are a combinational decode of the registered state (Moore); no output depends on inputs.
- Reset: state=INICIAL. Reset values: zeraN=zeraT=zeraP=zeraM=1; all others 0; db_estado=0.
- INICIAL (0): zeraN, zeraT, zeraP, zeraM. iniciar=1 -> PREPARA.
- PREPARA (1): zeraM, zeraT, zeraP (level counter kept). Unconditional -> JOGANDO. Gives the matrix one reset cycle with the settled level.
- JOGANDO (2): all outputs 0. nivel_concluido=1 -> PISCA_ACESO.
- PISCA_ACESO (3): passou_nivel=1, contaT=1 (all-on pattern, ganhou=0). fimT=1 -> PISCA_APAGADO.
- PISCA_APAGADO (4): contaT=1, passou_nivel=0 (solved board shown). fimT=1 and fimP=1 -> DECIDE. fimT=1 and fimP=0 -> CONTA_PISCA.
- CONTA_PISCA (5): contaP=1, zeraT=1, for one cycle -> PISCA_ACESO. This yields exactly 3 on-phases per level (P increments 0->1->2; fimP at 2).
- DECIDE (6): zeraT, zeraP. nivelIgualUltimoNivel=1 -> VITORIA, else -> PROXIMO.
- PROXIMO (7): contaN=1 for exactly one cycle -> PREPARA.
- VITORIA (8): passou_nivel=1, ganhou=1. Internal counter clears on entry and increments each cycle. After ESPERA_VITORIA cycles in state -> INICIAL. iniciar=1 at any time -> INICIAL (priority over the counter).
- Unused codes (9-15) -> INICIAL on the next edge.
- Simultaneous fimT and nivel_concluido are irrelevant: each input is examined only in its own state.
- iniciar is ignored outside INICIAL and VITORIA. An asserted reset mid-game aborts to INICIAL asynchronously; the datapath is cleared by INICIAL's zero signals on the next cycles.
- contaN and contaP are never asserted for more than one consecutive cycle.

Optional Feature:
TIMEOUT_EN. When defined:
- adds output perdeu (1 bit) and state PERDEU (9).
- A W_LIMITE counter clears in PREPARA and counts in JOGANDO.
- Reaching TEMPO_LIMITE-1 in JOGANDO with nivel_concluido=0 -> PERDEU. nivel_concluido=1 in the same cycle wins (-> PISCA_ACESO).
- PERDEU: perdeu=1, zeraM=1; iniciar=1 -> INICIAL.
When not defined: no perdeu port, no counter, and code 9 is unused.

Decomposition:
- Header estados_jogo.vh holds the state code localparams (INICIAL..PERDEU) and the 4-bit state width; fluxo_dados debug decoding shares it.
- No dedicated sub-module. Both the victory-hold and timeout counters are instances of the existing contador_m (zera_s driven by state entry, conta by state decode, fim used as the terminal condition).

Test Plan:
- Reset low mid-JOGANDO -> state 0 immediately, zeraN=zeraM=1, contaN=0.
- iniciar pulse in INICIAL -> PREPARA for 1 cycle (zeraM=1), then JOGANDO with all outputs 0.
- nivel_concluido in JOGANDO, datapath model with fimT every 500 cycles and fimP at count 2 -> exactly 3 passou_nivel high phases, 2 contaP pulses, then DECIDE.
- Level 2 completion, nivelIgualUltimoNivel=0 -> single-cycle contaN, PREPARA, JOGANDO; level model reads 3.
- Final level, nivelIgualUltimoNivel=1 -> VITORIA with ganhou=passou_nivel=1 for 2000 cycles, then INICIAL. Repeat with iniciar at cycle 10 -> INICIAL at cycle 11.
- TIMEOUT_EN, TEMPO_LIMITE=100: no completion -> PERDEU after 100 JOGANDO cycles with perdeu=1. Completion at cycle 99 -> PISCA_ACESO.

Source files
------------

// File: rtl/unidade_controle_jogo_pkg.sv
// unidade_controle_jogo_pkg: state codes shared by the game controller and the datapath debug decode
package unidade_controle_jogo_pkg;
   localparam int W_ESTADO = 4;
   typedef enum logic [W_ESTADO-1:0] {
      INICIAL       = 4'd0,
      PREPARA       = 4'd1,
      JOGANDO       = 4'd2,
      PISCA_ACESO   = 4'd3,
      PISCA_APAGADO = 4'd4,
      CONTA_PISCA   = 4'd5,
      DECIDE        = 4'd6,
      PROXIMO       = 4'd7,
      VITORIA       = 4'd8,
      PERDEU        = 4'd9
   } estado_t;
endpackage

// File: rtl/unidade_controle_jogo_if.sv
// unidade_controle_jogo_if: controller/datapath control and status bundle (perdeu only with TIMEOUT_EN)
interface unidade_controle_jogo_if;
   import unidade_controle_jogo_pkg::*;
   logic iniciar, nivel_concluido, fimT, fimP, nivelIgualUltimoNivel;
   logic contaN, zeraN, contaT, zeraT, contaP, zeraP, zeraM, ganhou, passou_nivel;
   logic [W_ESTADO-1:0] db_estado;
`ifdef TIMEOUT_EN
   logic perdeu;
   modport master (
      input  iniciar, nivel_concluido, fimT, fimP, nivelIgualUltimoNivel,
      output contaN, zeraN, contaT, zeraT, contaP, zeraP, zeraM, ganhou, passou_nivel, db_estado, perdeu
   );
   modport slave (
      output iniciar, nivel_concluido, fimT, fimP, nivelIgualUltimoNivel,
      input  contaN, zeraN, contaT, zeraT, contaP, zeraP, zeraM, ganhou, passou_nivel, db_estado, perdeu
   );
`else
   modport master (
      input  iniciar, nivel_concluido, fimT, fimP, nivelIgualUltimoNivel,
      output contaN, zeraN, contaT, zeraT, contaP, zeraP, zeraM, ganhou, passou_nivel, db_estado
   );
   modport slave (
      output iniciar, nivel_concluido, fimT, fimP, nivelIgualUltimoNivel,
      input  contaN, zeraN, contaT, zeraT, contaP, zeraP, zeraM, ganhou, passou_nivel, db_estado
   );
`endif
endinterface

// File: rtl/unidade_controle_jogo_contador.sv
// contador_m: modulo-M counter with synchronous clear and terminal-count flag
module contador_m #(
   parameter int M = 2000,
   parameter int N = 11
) (
   input  logic clock,
   input  logic reset,
   input  logic zera_s,
   input  logic conta,
   output logic fim
);
   logic [N-1:0] q_q, q_d;
   always_comb begin
      fim = q_q == N'(M - 1);
      q_d = zera_s ? '0 : conta ? (fim ? '0 : q_q + 1'b1) : q_q;
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) q_q <= '0;
      else q_q <= q_d;
endmodule

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing the LED-matrix puzzle datapath.
// TIMEOUT_EN adds the per-level time limit, the PERDEU state and the perdeu output.
module unidade_controle_jogo
   import unidade_controle_jogo_pkg::*;
#(
   parameter int ESPERA_VITORIA = 2000,
   parameter int W_ESPERA = 11
`ifdef TIMEOUT_EN
   , parameter int TEMPO_LIMITE = 60000,
   parameter int W_LIMITE = 16
`endif
) (
   input logic clock,
   input logic reset,
   unidade_controle_jogo_if.master ctl
);
   estado_t estado_q, estado_d;
   logic fim_espera;
   // victory hold counter sits at zero outside VITORIA, so it restarts on every entry
   contador_m #(.M(ESPERA_VITORIA), .N(W_ESPERA)) u_espera (
      .clock(clock), .reset(reset),
      .zera_s(estado_q != VITORIA), .conta(estado_q == VITORIA), .fim(fim_espera)
   );
`ifdef TIMEOUT_EN
   logic fim_limite;
   contador_m #(.M(TEMPO_LIMITE), .N(W_LIMITE)) u_limite (
      .clock(clock), .reset(reset),
      .zera_s(estado_q == PREPARA), .conta(estado_q == JOGANDO), .fim(fim_limite)
   );
`endif
   always_ff @(posedge clock or negedge reset)
      if (!reset) estado_q <= INICIAL;
      else estado_q <= estado_d;
   always_comb begin
      estado_d = INICIAL;
      case (estado_q)
         INICIAL:       estado_d = ctl.iniciar ? PREPARA : INICIAL;
         PREPARA:       estado_d = JOGANDO;
`ifdef TIMEOUT_EN
         JOGANDO:       estado_d = ctl.nivel_concluido ? PISCA_ACESO : fim_limite ? PERDEU : JOGANDO;
         PERDEU:        estado_d = ctl.iniciar ? INICIAL : PERDEU;
`else
         JOGANDO:       estado_d = ctl.nivel_concluido ? PISCA_ACESO : JOGANDO;
`endif
         PISCA_ACESO:   estado_d = ctl.fimT ? PISCA_APAGADO : PISCA_ACESO;
         PISCA_APAGADO: estado_d = !ctl.fimT ? PISCA_APAGADO : ctl.fimP ? DECIDE : CONTA_PISCA;
         CONTA_PISCA:   estado_d = PISCA_ACESO;
         DECIDE:        estado_d = ctl.nivelIgualUltimoNivel ? VITORIA : PROXIMO;
         PROXIMO:       estado_d = PREPARA;
         VITORIA:       estado_d = (ctl.iniciar || fim_espera) ? INICIAL : VITORIA;
         default:       estado_d = INICIAL;
      endcase
   end
   always_comb begin
      ctl.zeraN        = estado_q == INICIAL;
      ctl.zeraT        = estado_q inside {INICIAL, PREPARA, CONTA_PISCA, DECIDE};
      ctl.zeraP        = estado_q inside {INICIAL, PREPARA, DECIDE};
      ctl.contaT       = estado_q inside {PISCA_ACESO, PISCA_APAGADO};
      ctl.contaP       = estado_q == CONTA_PISCA;
      ctl.contaN       = estado_q == PROXIMO;
      ctl.ganhou       = estado_q == VITORIA;
      ctl.passou_nivel = estado_q inside {PISCA_ACESO, VITORIA};
      ctl.db_estado    = estado_q;
`ifdef TIMEOUT_EN
      ctl.zeraM        = estado_q inside {INICIAL, PREPARA, PERDEU};
      ctl.perdeu       = estado_q == PERDEU;
`else
      ctl.zeraM        = estado_q inside {INICIAL, PREPARA};
`endif
   end
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: scripted-random game sessions against a datapath model with a per-cycle scoreboard
module tb_unidade_controle_jogo;
   localparam int ESPERA = 2000;
   localparam int INI = 0, PREP = 1, JOG = 2, ACE = 3, APA = 4, CON = 5, DEC = 6, PROX = 7, VIT = 8;
   // {contaN, zeraN, contaT, zeraT, contaP, zeraP, zeraM, ganhou, passou_nivel} per state code
   localparam logic [8:0] TAB [0:8] = '{
      9'b010101100, 9'b000101100, 9'b000000000, 9'b001000001, 9'b001000000,
      9'b000110000, 9'b000101000, 9'b100000000, 9'b000000011
   };
   logic clock = 1'b0;
   logic reset = 1'b0;
   int compared = 0, mismatched = 0;
   int L = 2, ultimo = 0;
   int t_cnt = 0, p_cnt = 0, n_cnt = 0;
   int exp_q[$];
   int e_mon;
   logic [8:0] outs;
   unidade_controle_jogo_if ifc ();
   unidade_controle_jogo dut (.clock(clock), .reset(reset), .ctl(ifc));
   always #5 clock = ~clock;
   assign outs = {ifc.contaN, ifc.zeraN, ifc.contaT, ifc.zeraT, ifc.contaP, ifc.zeraP, ifc.zeraM, ifc.ganhou, ifc.passou_nivel};
   assign ifc.fimT = t_cnt == L - 1;
   assign ifc.fimP = p_cnt == 2;
   assign ifc.nivelIgualUltimoNivel = n_cnt == ultimo;
   // datapath model: blink timer, blink counter and level counter driven by the controller's enables
   always @(posedge clock) begin
      t_cnt <= ifc.zeraT ? 0 : ifc.contaT ? ((t_cnt == L - 1) ? 0 : t_cnt + 1) : t_cnt;
      p_cnt <= ifc.zeraP ? 0 : ifc.contaP ? p_cnt + 1 : p_cnt;
      n_cnt <= ifc.zeraN ? 0 : ifc.contaN ? n_cnt + 1 : n_cnt;
   end
   task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s t=%0t state/outs actual=%h required=%h", name, $time, act, req);
      end
   endtask
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         check("cycle", {ifc.db_estado, outs}, {4'(e_mon), TAB[e_mon]});
      end
   end
   task automatic cyc(input int e);
      exp_q.push_back(e);
      @(negedge clock);
   endtask
   task automatic noise();
      ifc.iniciar = 1'($urandom_range(0, 1));
      ifc.nivel_concluido = 1'($urandom_range(0, 1));
   endtask
   task automatic play_game(input int g);
      int k, lvl, j;
      bit fim;
      ultimo = (g == 0) ? 3 : (g == 1) ? 2 : int'($urandom_range(0, 3));
      ifc.nivel_concluido = 1'b0;
      ifc.iniciar = 1'b1;
      cyc(PREP);
      noise();
      cyc(JOG);
      lvl = 0;
      fim = 1'b0;
      while (!fim) begin
         L = $urandom_range(2, 6);
         k = $urandom_range(0, 6);
         repeat (k) begin
            ifc.iniciar = 1'($urandom_range(0, 1));
            ifc.nivel_concluido = 1'b0;
            cyc(JOG);
         end
         if (g == 1 && lvl == 1) begin
            ifc.iniciar = 1'b0;
            ifc.nivel_concluido = 1'b0;
            reset = 1'b0;
            #1;
            check("async_reset", {ifc.db_estado, outs}, {4'(INI), TAB[INI]});
            cyc(INI);
            reset = 1'b1;
            cyc(INI);
            return;
         end
         ifc.nivel_concluido = 1'b1;
         cyc(ACE);
         for (int ph = 0; ph < 3; ph++) begin
            repeat (L - 1) begin noise(); cyc(ACE); end
            repeat (L) begin noise(); cyc(APA); end
            noise();
            if (ph < 2) begin
               cyc(CON);
               noise();
               cyc(ACE);
            end else cyc(DEC);
         end
         noise();
         if (lvl == ultimo) begin
            cyc(VIT);
            fim = 1'b1;
         end else begin
            cyc(PROX);
            noise();
            cyc(PREP);
            noise();
            cyc(JOG);
            lvl++;
         end
      end
      j = (g == 0) ? 10 : (g == 2) ? ESPERA : int'($urandom_range(1, ESPERA));
      ifc.iniciar = 1'b0;
      repeat (j - 1) begin
         ifc.nivel_concluido = 1'($urandom_range(0, 1));
         cyc(VIT);
      end
      ifc.iniciar = j < ESPERA;
      cyc(INI);
      ifc.iniciar = 1'b0;
      cyc(INI);
   endtask
   initial begin
      ifc.iniciar = 1'b0;
      ifc.nivel_concluido = 1'b0;
      @(negedge clock);
      cyc(INI);
      ifc.iniciar = 1'b1;
      cyc(INI);
      reset = 1'b1;
      ifc.iniciar = 1'b0;
      cyc(INI);
      for (int g = 0; g < 6; g++) play_game(g);
      repeat (2) @(negedge clock);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t expired before end of stimulus", $time);
      $fatal(1, "timeout");
   end
endmodule
